dmem_arbiter: RTL and testbench

Arbitrates the single-port data RAM between two requesters: the CPU memory stage (load/store) and the program/data loader (testbench or boot loader, multi-word bursts).
- Sits between the memory pipeline stage and the data RAM instance.
- Gives the CPU fixed priority, with aging so the loader cannot starve.
- Supports a loader lock for atomic bursts.
- Returns read data one cycle after grant and drives the pipeline stall.

---
 rtl/dmem_pkg.sv | 7 +
 rtl/dmem_rd_return.sv | 27 ++
 rtl/dmem_arbiter.sv | 73 +++++++
 tb/tb_dmem_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-RAM arbiter.
package dmem_pkg;
   typedef enum logic {ARB, LOCK} arb_state_t;
   localparam int WAIT_W = 4;
   localparam int REQ_CPU = 0;
   localparam int REQ_LDR = 1;
endpackage

// File: rtl/dmem_rd_return.sv
// dmem_rd_return: remembers which requester issued a read and steers the
// synchronous RAM read data back to it one cycle later.
module dmem_rd_return
   import dmem_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       rd_i,
   input  logic [WIDTH-1:0] ram_rdata_i,
   output logic [1:0]       rvalid_o,
   output logic [WIDTH-1:0] cpu_rdata_o,
   output logic [WIDTH-1:0] ldr_rdata_o
);
   logic [1:0] owner_d, owner_q;
   always_comb begin
      owner_d = rd_i;
      rvalid_o = rst ? 2'b00 : owner_q;
      cpu_rdata_o = rvalid_o[REQ_CPU] ? ram_rdata_i : '0;
      ldr_rdata_o = rvalid_o[REQ_LDR] ? ram_rdata_i : '0;
   end
   always_ff @(posedge clk) begin
      if (rst) owner_q <= 2'b00;
      else owner_q <= owner_d;
   end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: single-port data RAM arbiter between the CPU memory stage and
// the loader; CPU has priority, an aging counter and a lock protect the loader.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cpu_req_i,
   input  logic             cpu_we_i,
   input  logic [WIDTH-1:0] cpu_adr_i,
   input  logic [WIDTH-1:0] cpu_wdata_i,
   output logic             cpu_gnt_o,
   output logic             cpu_rvalid_o,
   output logic [WIDTH-1:0] cpu_rdata_o,
   output logic             cpu_stall_o,
   input  logic             ldr_req_i,
   input  logic             ldr_we_i,
   input  logic [WIDTH-1:0] ldr_adr_i,
   input  logic [WIDTH-1:0] ldr_wdata_i,
   input  logic             ldr_lock_i,
   output logic             ldr_gnt_o,
   output logic             ldr_rvalid_o,
   output logic [WIDTH-1:0] ldr_rdata_o,
   output logic [WIDTH-1:0] ram_adr_o,
   output logic [WIDTH-1:0] ram_wdata_o,
   output logic             ram_we_o,
   input  logic [WIDTH-1:0] ram_rdata_i
);
   localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);
   arb_state_t state_d, state_q;
   logic [WAIT_W-1:0] wait_d, wait_q;
   logic [1:0] rd, rvalid;
   always_comb begin
      cpu_gnt_o = 1'b0;
      ldr_gnt_o = 1'b0;
      if (!rst) begin
         ldr_gnt_o = (state_q == LOCK) ? ldr_req_i : ldr_req_i & (~cpu_req_i | (wait_q == MAX_W));
         cpu_gnt_o = (state_q == ARB) & cpu_req_i & ~ldr_gnt_o;
      end
      // LOCK is left at the end of any cycle where the loader drops lock
      state_d = (state_q == ARB) ? ((ldr_gnt_o & ldr_lock_i) ? LOCK : ARB) : (ldr_lock_i ? LOCK : ARB);
      wait_d = (ldr_req_i & ~ldr_gnt_o & (state_q == ARB)) ? ((wait_q == MAX_W) ? wait_q : wait_q + 1'b1) : '0;
      cpu_stall_o = cpu_req_i & ~cpu_gnt_o;
      ram_adr_o = ldr_gnt_o ? ldr_adr_i : cpu_adr_i;
      ram_wdata_o = ldr_gnt_o ? ldr_wdata_i : cpu_wdata_i;
      ram_we_o = ldr_gnt_o ? ldr_we_i : cpu_gnt_o & cpu_we_i;
      rd[REQ_CPU] = cpu_gnt_o & ~cpu_we_i;
      rd[REQ_LDR] = ldr_gnt_o & ~ldr_we_i;
      cpu_rvalid_o = rvalid[REQ_CPU];
      ldr_rvalid_o = rvalid[REQ_LDR];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB;
         wait_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q <= wait_d;
      end
   end
   dmem_rd_return #(.WIDTH(WIDTH)) u_rd_return (
      .clk(clk),
      .rst(rst),
      .rd_i(rd),
      .ram_rdata_i(ram_rdata_i),
      .rvalid_o(rvalid),
      .cpu_rdata_o(cpu_rdata_o),
      .ldr_rdata_o(ldr_rdata_o)
   );
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors with a read-data scoreboard; a monitor pops
// expected read data whenever the arbiter presents rvalid.
module tb_dmem_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cpu_req_i = 1'b0, cpu_we_i = 1'b0, ldr_req_i = 1'b0, ldr_we_i = 1'b0, ldr_lock_i = 1'b0;
   logic [31:0] cpu_adr_i = '0, cpu_wdata_i = '0, ldr_adr_i = '0, ldr_wdata_i = '0;
   logic cpu_gnt_o, cpu_rvalid_o, cpu_stall_o, ldr_gnt_o, ldr_rvalid_o, ram_we_o;
   logic [31:0] cpu_rdata_o, ldr_rdata_o, ram_adr_o, ram_wdata_o, ram_rdata_i;
   logic [31:0] mem [64];
   logic [31:0] cpu_q [$];
   logic [31:0] ldr_q [$];
   int checks = 0;
   int errors = 0;
   bit run = 1'b0;

   always #5 clk = ~clk;

   dmem_arbiter #(.WIDTH(32), .MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_adr_i(cpu_adr_i), .cpu_wdata_i(cpu_wdata_i),
      .cpu_gnt_o(cpu_gnt_o), .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
      .ldr_req_i(ldr_req_i), .ldr_we_i(ldr_we_i), .ldr_adr_i(ldr_adr_i), .ldr_wdata_i(ldr_wdata_i),
      .ldr_lock_i(ldr_lock_i), .ldr_gnt_o(ldr_gnt_o), .ldr_rvalid_o(ldr_rvalid_o), .ldr_rdata_o(ldr_rdata_o),
      .ram_adr_o(ram_adr_o), .ram_wdata_o(ram_wdata_o), .ram_we_o(ram_we_o), .ram_rdata_i(ram_rdata_i)
   );

   // Synchronous read-first RAM
   always @(posedge clk) begin
      if (ram_we_o) mem[ram_adr_o[7:2]] <= ram_wdata_o;
      ram_rdata_i <= mem[ram_adr_o[7:2]];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (run) begin
         if (cpu_rvalid_o) begin
            if (cpu_q.size() == 0) chk("cpu_rvalid_unexpected", 32'(cpu_rvalid_o), 32'd0);
            else chk("cpu_rdata", cpu_rdata_o, cpu_q.pop_front());
         end else chk("cpu_rdata_idle", cpu_rdata_o, 32'd0);
         if (ldr_rvalid_o) begin
            if (ldr_q.size() == 0) chk("ldr_rvalid_unexpected", 32'(ldr_rvalid_o), 32'd0);
            else chk("ldr_rdata", ldr_rdata_o, ldr_q.pop_front());
         end else chk("ldr_rdata_idle", ldr_rdata_o, 32'd0);
      end
   end

   task automatic step(input logic r, input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic lr, input logic lw, input logic [31:0] la, input logic [31:0] ld, input logic lk,
                       input logic ecg, input logic elg, input logic est, input logic [31:0] erd, input string nm);
      @(posedge clk);
      #1;
      rst = r;
      cpu_req_i = cr; cpu_we_i = cw; cpu_adr_i = ca; cpu_wdata_i = cd;
      ldr_req_i = lr; ldr_we_i = lw; ldr_adr_i = la; ldr_wdata_i = ld; ldr_lock_i = lk;
      if (r) begin
         cpu_q.delete();
         ldr_q.delete();
      end
      @(negedge clk);
      chk({nm, ".cpu_gnt"}, 32'(cpu_gnt_o), 32'(ecg));
      chk({nm, ".ldr_gnt"}, 32'(ldr_gnt_o), 32'(elg));
      chk({nm, ".stall"}, 32'(cpu_stall_o), 32'(est));
      chk({nm, ".ram_we"}, 32'(ram_we_o), 32'((ecg & cw) | (elg & lw)));
      if (ecg & ~cw) cpu_q.push_back(erd);
      if (elg & ~lw) ldr_q.push_back(erd);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
   endtask

   initial begin
      foreach (mem[i]) mem[i] = 32'h1000_0000 + i;
      mem[32'h10 >> 2] = 32'hDEADBEEF;
      mem[32'h20 >> 2] = 32'hA5A5_0020;
      mem[32'h24 >> 2] = 32'h5A5A_0024;
      // reset: grants and RAM write suppressed even with requests present
      step(1, 1, 1, 32'h40, 32'hBAD, 1, 1, 0, 32'hBAD, 0, 0, 0, 1, 0, "rst0");
      run = 1'b1;
      step(1, 1, 1, 32'h40, 32'hBAD, 1, 1, 0, 32'hBAD, 0, 0, 0, 1, 0, "rst1");
      idle();
      // CPU read only
      step(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'hDEADBEEF, "cpu_rd");
      idle();
      // contention: CPU wins four times, then loader after aging
      for (int i = 0; i < 4; i++)
         step(0, 1, 0, 32'h10, 0, 1, 0, 32'h20, 0, 0, 1, 0, 0, 32'hDEADBEEF, "cont_cpu");
      step(0, 1, 0, 32'h10, 0, 1, 0, 32'h20, 0, 0, 0, 1, 1, 32'hA5A50020, "cont_ldr");
      step(0, 1, 0, 32'h10, 0, 1, 0, 32'h20, 0, 0, 1, 0, 0, 32'hDEADBEEF, "cont_reset");
      step(0, 0, 0, 0, 0, 1, 0, 32'h20, 0, 0, 0, 1, 0, 32'hA5A50020, "ldr_only");
      // locked burst: lock ignored until the loader wins by aging
      for (int i = 0; i < 4; i++)
         step(0, 1, 0, 32'h10, 0, 1, 1, 32'h0, 32'h11, 1, 1, 0, 0, 32'hDEADBEEF, "nolock");
      step(0, 1, 0, 32'h10, 0, 1, 1, 32'h0, 32'h11, 1, 0, 1, 1, 0, "burst0");
      step(0, 1, 0, 32'h10, 0, 1, 1, 32'h4, 32'h22, 1, 0, 1, 1, 0, "burst1");
      step(0, 1, 0, 32'h10, 0, 1, 1, 32'h8, 32'h33, 0, 0, 1, 1, 0, "burst2");
      step(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'hDEADBEEF, "after_burst");
      // back-to-back mixed reads
      step(0, 1, 0, 32'h20, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'hA5A50020, "b2b_cpu");
      step(0, 0, 0, 0, 0, 1, 0, 32'h24, 0, 0, 0, 1, 0, 32'h5A5A0024, "b2b_ldr");
      step(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'hDEADBEEF, "b2b_cpu2");
      idle();
      // reset mid-LOCK with a loader read in flight
      step(0, 0, 0, 0, 0, 1, 0, 32'h24, 0, 1, 0, 1, 0, 32'h5A5A0024, "lock_rd");
      step(1, 0, 0, 0, 0, 1, 0, 32'h24, 0, 1, 0, 0, 0, 0, "lock_rst");
      step(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'hDEADBEEF, "post_rst");
      chk("post_rst.ldr_rvalid", 32'(ldr_rvalid_o), 32'd0);
      idle();
      // CPU write then read of the same address, and readback of a burst word
      step(0, 1, 1, 32'h40, 32'h12345678, 0, 0, 0, 0, 0, 1, 0, 0, 0, "cpu_wr");
      step(0, 1, 0, 32'h40, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h12345678, "cpu_rd40");
      step(0, 1, 0, 32'h4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h22, "cpu_rd4");
      idle();
      idle();
      chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
      chk("ldr_q_drained", 32'(ldr_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
